// File: rtl/bcd_digit_mul_if.sv
// Operand/product bundle between the BCD multiplier, its operand source and the accumulator.
// ERR exists only when BCD_CHECK_EN is defined.
interface bcd_digit_mul_if;
    logic [3:0] a;
    logic [3:0] b;
    logic       start;
    logic       ready;
    logic [3:0] il;
    logic [3:0] ih;
    logic       pv;
    logic       last;
`ifdef BCD_CHECK_EN
    logic       err;

    modport master (output a, b, start, input ready, il, ih, pv, last, err);
    modport slave  (input a, b, start, output ready, il, ih, pv, last, err);
`else
    modport master (output a, b, start, input ready, il, ih, pv, last);
    modport slave  (input a, b, start, output ready, il, ih, pv, last);
`endif
endinterface

// File: rtl/bcd_digit_mul.sv
// Single-digit BCD multiplier by repeated decimal addition; product pulsed one cycle on IL/IH (zero otherwise).
// Latency: PV in the cycle after edge t+B+1 for START accepted on edge t; START is only sampled while READY=1.
// Optional BCD_CHECK_EN: non-BCD operands short-circuit to a zero product flagged with ERR.
module bcd_digit_mul #(
    parameter int unsigned N = 3
) (
    input  logic          clk_i,
    input  logic          clr_ni,
    bcd_digit_mul_if.slave bus
);

    localparam logic [3:0] LAST_IDX = 4'(N - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_MUL,
        S_OUT
    } state_t;

    state_t     state_q;
    logic [3:0] ra_q;
    logic [3:0] rb_q;
    logic [3:0] pl_q;
    logic [3:0] ph_q;
    logic [3:0] cnt_q;
    logic       ready_q;
    logic [3:0] il_q;
    logic [3:0] ih_q;
    logic       pv_q;
    logic       last_q;
`ifdef BCD_CHECK_EN
    logic       err_pend_q;
    logic       err_q;
    logic       bad_in;
`endif

    logic [4:0] sum_d;
    logic [3:0] pl_d;
    logic [3:0] ph_d;
    logic [3:0] rb_d;
    logic       last_elem;

    always_comb begin
        sum_d     = {1'b0, pl_q} + {1'b0, ra_q};
        pl_d      = sum_d[3:0];
        ph_d      = ph_q;
        // Decimal carry: a units sum above 9 wraps and bumps the tens digit.
        if (sum_d > 5'd9) begin
            pl_d = 4'(sum_d - 5'd10);
            ph_d = ph_q + 4'd1;
        end
        rb_d      = rb_q - 4'd1;
        last_elem = (cnt_q == LAST_IDX);
    end

`ifdef BCD_CHECK_EN
    assign bad_in = (bus.a > 4'd9) || (bus.b > 4'd9);
`endif

    always_ff @(posedge clk_i) begin
        if (!clr_ni) begin
            state_q    <= S_IDLE;
            ra_q       <= '0;
            rb_q       <= '0;
            pl_q       <= '0;
            ph_q       <= '0;
            cnt_q      <= '0;
            ready_q    <= 1'b1;
            il_q       <= '0;
            ih_q       <= '0;
            pv_q       <= 1'b0;
            last_q     <= 1'b0;
`ifdef BCD_CHECK_EN
            err_pend_q <= 1'b0;
            err_q      <= 1'b0;
`endif
        end else begin
            // Outputs default to zero so the accumulator sees data only on PV.
            pv_q   <= 1'b0;
            il_q   <= '0;
            ih_q   <= '0;
            last_q <= 1'b0;
`ifdef BCD_CHECK_EN
            err_q  <= 1'b0;
`endif
            case (state_q)
                S_IDLE: begin
                    if (bus.start) begin
                        ready_q <= 1'b0;
`ifdef BCD_CHECK_EN
                        if (bad_in) begin
                            err_pend_q <= 1'b1;
                            state_q    <= S_OUT;
                        end else begin
                            err_pend_q <= 1'b0;
                            ra_q       <= bus.a;
                            rb_q       <= bus.b;
                            pl_q       <= '0;
                            ph_q       <= '0;
                            state_q    <= (bus.b != 4'd0) ? S_MUL : S_OUT;
                        end
`else
                        ra_q    <= bus.a;
                        rb_q    <= bus.b;
                        pl_q    <= '0;
                        ph_q    <= '0;
                        state_q <= (bus.b != 4'd0) ? S_MUL : S_OUT;
`endif
                    end
                end
                S_MUL: begin
                    pl_q <= pl_d;
                    ph_q <= ph_d;
                    rb_q <= rb_d;
                    if (rb_q == 4'd1) begin
                        state_q <= S_OUT;
                    end
                end
                S_OUT: begin
                    pv_q    <= 1'b1;
                    last_q  <= last_elem;
                    cnt_q   <= last_elem ? 4'd0 : cnt_q + 4'd1;
                    state_q <= S_IDLE;
                    ready_q <= 1'b1;
`ifdef BCD_CHECK_EN
                    err_q      <= err_pend_q;
                    err_pend_q <= 1'b0;
                    il_q       <= err_pend_q ? 4'd0 : pl_q;
                    ih_q       <= err_pend_q ? 4'd0 : ph_q;
`else
                    il_q    <= pl_q;
                    ih_q    <= ph_q;
`endif
                end
                default: begin
                    state_q <= S_IDLE;
                    ready_q <= 1'b1;
                end
            endcase
        end
    end

    assign bus.ready = ready_q;
    assign bus.il    = il_q;
    assign bus.ih    = ih_q;
    assign bus.pv    = pv_q;
    assign bus.last  = last_q;
`ifdef BCD_CHECK_EN
    assign bus.err   = err_q;
`endif

endmodule

// File: tb/tb_bcd_digit_mul.sv
// Directed + random bench for bcd_digit_mul against an arithmetic product/latency/row-position model.
module tb_bcd_digit_mul;

    localparam int N = 3;

    logic clk = 1'b0;
    logic clr_n = 1'b0;
    always #5 clk = ~clk;

    bcd_digit_mul_if bus ();

    bcd_digit_mul #(.N(N)) dut (
        .clk_i (clk),
        .clr_ni(clr_n),
        .bus   (bus)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int mcnt  = 0;
    int pa[$];
    int pb[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // Feeds pa/pb with START held high, checking each product, its timing and row position.
    task automatic run_stream();
        int npairs = pa.size();
        int fed = 0;
        int got = 0;
        int guard = 0;
        int e_cyc[$];
        int e_lo[$];
        int e_hi[$];
        int e_last[$];
        while (got < npairs && guard < 20 * npairs + 20) begin
            if (bus.ready === 1'b1 && fed < npairs) begin
                bus.a     = 4'(pa[fed]);
                bus.b     = 4'(pb[fed]);
                bus.start = 1'b1;
                e_cyc.push_back(cyc + 1 + pb[fed] + 1);
                e_lo.push_back((pa[fed] * pb[fed]) % 10);
                e_hi.push_back((pa[fed] * pb[fed]) / 10);
                e_last.push_back(mcnt == N - 1 ? 1 : 0);
                mcnt = (mcnt + 1) % N;
                fed++;
            end else if (fed >= npairs) begin
                bus.start = 1'b0;
            end
            step();
            guard++;
            if (bus.pv === 1'b1) begin
                chk("pv_cycle", 32'(cyc), 32'(e_cyc.pop_front()));
                chk("il", 32'(bus.il), 32'(e_lo.pop_front()));
                chk("ih", 32'(bus.ih), 32'(e_hi.pop_front()));
                chk("last", 32'(bus.last), 32'(e_last.pop_front()));
                chk("ready_at_pv", 32'(bus.ready), 32'd1);
                got++;
            end else begin
                chk("idle_zero", {24'd0, bus.ih, bus.il}, 32'd0);
                chk("idle_last", 32'(bus.last), 32'd0);
            end
`ifdef BCD_CHECK_EN
            chk("err_quiet", 32'(bus.err), 32'd0);
`endif
        end
        bus.start = 1'b0;
        chk("stream_done", 32'(got), 32'(npairs));
        pa.delete();
        pb.delete();
    endtask

    initial begin
        bus.a = 4'd0;
        bus.b = 4'd0;
        bus.start = 1'b0;

        // Reset held two cycles.
        clr_n = 1'b0;
        step();
        step();
        clr_n = 1'b1;
        chk("rst_ready", 32'(bus.ready), 32'd1);
        chk("rst_il", 32'(bus.il), 32'd0);
        chk("rst_ih", 32'(bus.ih), 32'd0);
        chk("rst_pv", 32'(bus.pv), 32'd0);
        chk("rst_last", 32'(bus.last), 32'd0);
        mcnt = 0;

        // 7x8: READY low for 9 cycles, then 56.
        bus.a = 4'd7;
        bus.b = 4'd8;
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        for (int i = 0; i < 9; i++) begin
            chk("busy_ready", 32'(bus.ready), 32'd0);
            chk("busy_pv", 32'(bus.pv), 32'd0);
            step();
        end
        chk("m78_pv", 32'(bus.pv), 32'd1);
        chk("m78_ih", 32'(bus.ih), 32'd5);
        chk("m78_il", 32'(bus.il), 32'd6);
        chk("m78_ready", 32'(bus.ready), 32'd1);
        mcnt = 1;
        step();
        chk("m78_after", {24'd0, bus.ih, bus.il, 3'd0, bus.pv}, 32'd0);

        // Zero operands, including B=0 short path and A=0 full loop.
        pa = '{9};
        pb = '{0};
        run_stream();
        pa = '{0};
        pb = '{9};
        run_stream();

        // Back-to-back row with START held high; 81 closes the row.
        pa = '{2, 4, 9, 1};
        pb = '{3, 5, 9, 1};
        run_stream();

        // Reset in the middle of 6x9 discards the product and the row position.
        step();
        bus.a = 4'd6;
        bus.b = 4'd9;
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        step();
        step();
        step();
        clr_n = 1'b0;
        step();
        clr_n = 1'b1;
        chk("midrst_ready", 32'(bus.ready), 32'd1);
        mcnt = 0;
        begin
            int seen = 0;
            for (int i = 0; i < 12; i++) begin
                step();
                if (bus.pv === 1'b1) seen++;
            end
            chk("midrst_no_pv", 32'(seen), 32'd0);
        end
        pa = '{3, 8, 5};
        pb = '{3, 2, 7};
        run_stream();

`ifdef BCD_CHECK_EN
        // Non-BCD operand: zero product flagged with ERR, row position still advances.
        bus.a = 4'd12;
        bus.b = 4'd3;
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        step();
        chk("err_pv", 32'(bus.pv), 32'd1);
        chk("err_flag", 32'(bus.err), 32'd1);
        chk("err_prod", {24'd0, bus.ih, bus.il}, 32'd0);
        chk("err_last", 32'(bus.last), (mcnt == N - 1) ? 32'd1 : 32'd0);
        mcnt = (mcnt + 1) % N;
        step();
        chk("err_clear", 32'(bus.err), 32'd0);
`endif

        // Random BCD operand pairs.
        for (int i = 0; i < 40; i++) begin
            pa.push_back($urandom_range(0, 9));
            pb.push_back($urandom_range(0, 9));
        end
        run_stream();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
